decode_operand_stage: RTL and testbench



---
 rtl/decode_operand_stage.sv | 190 +++++++++++++++++++
 tb/tb_decode_operand_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_operand_stage.sv
// =============================================================================
// Module      : decode_operand_stage
// Description : RV32I decode stage that issues register-unit reads, owns
//               register-unit port A (writeback writes take priority over rs1
//               reads) and presents a registered decoded bundle to execute.
//               Optional macro DECODE_WB_BYPASS_EN forwards writeback data
//               into captured and held operands.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module decode_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] rf_address_a,
    output logic [REG_AW-1:0] rf_address_b,
    output logic              rf_wren_a,
    output logic [DATA_W-1:0] rf_in_a,
    input  logic [DATA_W-1:0] rf_out_a,
    input  logic [DATA_W-1:0] rf_out_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_rs1_val,
    output logic [DATA_W-1:0] out_rs2_val,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_VALID = 2'd3;

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [1:0]         r_state;
    logic [31:0]        r_instr;
    logic [31:0]        r_pc;
    logic [31:0]        r_out_pc;
    logic [DATA_W-1:0]  r_out_imm;
    logic [DATA_W-1:0]  r_out_rs1;
    logic [DATA_W-1:0]  r_out_rs2;
    logic [6:0]         r_out_opcode;
    logic [2:0]         r_out_funct3;
    logic [6:0]         r_out_funct7;
    logic [4:0]         r_out_rd;
    logic               r_out_illegal;

    logic [6:0]         w_opcode;
    logic [REG_AW-1:0]  w_rs1;
    logic [REG_AW-1:0]  w_rs2;
    logic signed [31:0] w_imm32;
    logic               w_illegal;
    logic               w_wb_write;
    logic               w_byp_rs1;
    logic               w_byp_rs2;
    logic               w_accept;

    assign w_opcode   = r_instr[6:0];
    assign w_rs1      = REG_AW'(r_instr[19:15]);
    assign w_rs2      = REG_AW'(r_instr[24:20]);
    assign w_wb_write = wb_valid && (wb_rd != '0);

    // Writeback always wins port A; a write to x0 is suppressed entirely.
    assign rf_wren_a    = w_wb_write;
    assign rf_in_a      = wb_data;
    assign rf_address_a = wb_valid ? wb_rd : w_rs1;
    assign rf_address_b = w_rs2;

`ifdef DECODE_WB_BYPASS_EN
    assign w_byp_rs1 = w_wb_write && (wb_rd == w_rs1);
    assign w_byp_rs2 = w_wb_write && (wb_rd == w_rs2);
`else
    assign w_byp_rs1 = 1'b0;
    assign w_byp_rs2 = 1'b0;
`endif

    assign in_ready  = (r_state == c_IDLE) || ((r_state == c_VALID) && out_ready);
    assign w_accept  = in_ready && in_valid;
    assign out_valid = (r_state == c_VALID);

    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
            c_OP_STORE:
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
            c_OP_BRANCH:
                w_imm32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                           r_instr[30:25], r_instr[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm32 = {r_instr[31:12], 12'b0};
            c_OP_JAL:
                w_imm32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                           r_instr[20], r_instr[30:21], 1'b0};
            c_OP_REG:
                w_imm32 = '0;
            default:
                w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_instr       <= '0;
            r_pc          <= '0;
            r_out_pc      <= '0;
            r_out_imm     <= '0;
            r_out_rs1     <= '0;
            r_out_rs2     <= '0;
            r_out_opcode  <= '0;
            r_out_funct3  <= '0;
            r_out_funct7  <= '0;
            r_out_rd      <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_instr <= in_instr;
                r_pc    <= in_pc;
            end
            case (r_state)
                c_IDLE: begin
                    if (in_valid) r_state <= c_ISSUE;
                end
                c_ISSUE: begin
                    // Port A is busy with a writeback; the rs1 read must wait.
                    if (!wb_valid) r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_out_pc      <= r_pc;
                    r_out_imm     <= DATA_W'(w_imm32);
                    r_out_rs1     <= w_byp_rs1 ? wb_data : rf_out_a;
                    r_out_rs2     <= w_byp_rs2 ? wb_data : rf_out_b;
                    r_out_opcode  <= w_opcode;
                    r_out_funct3  <= r_instr[14:12];
                    r_out_funct7  <= r_instr[31:25];
                    r_out_rd      <= r_instr[11:7];
                    r_out_illegal <= w_illegal;
                    r_state       <= c_VALID;
                end
                c_VALID: begin
                    if (w_byp_rs1) r_out_rs1 <= wb_data;
                    if (w_byp_rs2) r_out_rs2 <= wb_data;
                    if (out_ready) r_state <= in_valid ? c_ISSUE : c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign out_pc      = r_out_pc;
    assign out_imm     = r_out_imm;
    assign out_rs1_val = r_out_rs1;
    assign out_rs2_val = r_out_rs2;
    assign out_opcode  = r_out_opcode;
    assign out_funct3  = r_out_funct3;
    assign out_funct7  = r_out_funct7;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_operand_stage.sv
// =============================================================================
// Module      : tb_decode_operand_stage
// Description : Self-checking bench for decode_operand_stage with a
//               behavioural register unit and an arithmetic decode model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_decode_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rf_address_a;
    logic [4:0]  rf_address_b;
    logic        rf_wren_a;
    logic [31:0] rf_in_a;
    logic [31:0] rf_out_a;
    logic [31:0] rf_out_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        out_illegal;

    decode_operand_stage #(.DATA_W(32), .REG_AW(5)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_address_a(rf_address_a), .rf_address_b(rf_address_b),
        .rf_wren_a(rf_wren_a), .rf_in_a(rf_in_a),
        .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register unit: synchronous write on port A, registered reads, x0 reads 0.
    logic        ru_init;
    logic [31:0] ru_regs [32];
    always @(posedge clk) begin
        if (ru_init) begin
            for (int i = 0; i < 32; i++) ru_regs[i] <= '0;
        end else if (rf_wren_a) begin
            ru_regs[rf_address_a] <= rf_in_a;
        end
        rf_out_a <= (rf_address_a == 5'd0) ? 32'd0 : ru_regs[rf_address_a];
        rf_out_b <= (rf_address_b == 5'd0) ? 32'd0 : ru_regs[rf_address_b];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Architectural register file as the model sees it.
    logic [31:0] gold [32];
    bit          pending;
    logic [31:0] exp_ins, exp_pc, exp_imm, exp_rs1, exp_rs2;
    logic        exp_ill;

    function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                       output logic ill);
        int s;
        int hi;
        s   = ins;
        ill = 1'b0;
        imm = '0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm = s >>> 20;
            7'b0100011: begin
                hi  = s >>> 25;
                imm = hi * 32 + int'(ins[11:7]);
            end
            7'b1100011: begin
                hi  = ins[31] ? -4096 : 0;
                imm = hi + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: imm = ins & 32'hFFFF_F000;
            7'b1101111: begin
                hi  = ins[31] ? -1048576 : 0;
                imm = hi + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                         + int'(ins[30:21]) * 2;
            end
            7'b0110011: imm = '0;
            default:    ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 12))
            0:  op = 7'b0010011;
            1:  op = 7'b0000011;
            2:  op = 7'b1100111;
            3:  op = 7'b1110011;
            4:  op = 7'b0100011;
            5:  op = 7'b1100011;
            6:  op = 7'b0110111;
            7:  op = 7'b0010111;
            8:  op = 7'b1101111;
            9:  op = 7'b0110011;
            10: op = 7'b0001111;
            11: op = 7'b1111111;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    task automatic check_bundle();
        check_eq("out_valid", out_valid, 1);
        check_eq("out_pc", out_pc, exp_pc);
        check_eq("out_imm", out_imm, exp_imm);
        check_eq("out_rs1_val", out_rs1_val, exp_rs1);
        check_eq("out_rs2_val", out_rs2_val, exp_rs2);
        check_eq("out_opcode", out_opcode, exp_ins[6:0]);
        check_eq("out_funct3", out_funct3, exp_ins[14:12]);
        check_eq("out_funct7", out_funct7, exp_ins[31:25]);
        check_eq("out_rd", out_rd, exp_ins[11:7]);
        check_eq("out_illegal", out_illegal, exp_ill);
    endtask

    // Applies a writeback that happened on the last edge while a bundle was held.
    task automatic apply_wb(input logic [4:0] rd, input logic [31:0] d,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        if (rd != 5'd0) begin
            gold[rd] = d;
`ifdef DECODE_WB_BYPASS_EN
            if (rd == rs1) exp_rs1 = d;
            if (rd == rs2) exp_rs2 = d;
`endif
        end
    endtask

    task automatic wb_idle(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        #1;
        check_eq("idle_wren", rf_wren_a, rd != 5'd0);
        check_eq("idle_addr_a", rf_address_a, rd);
        @(posedge clk);
        if (rd != 5'd0) gold[rd] = d;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // Entered and left at a negedge; leaves the new bundle held in VALID.
    task automatic do_txn(input logic [31:0] ins, input logic [31:0] pc, input int nstall,
                          input bit wait_wb, input logic [4:0] wait_rd,
                          input logic [31:0] wait_data, input int nhold, input bit hold_wb);
        logic [4:0]  rs1, rs2;
        logic [31:0] r;
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        out_ready = pending; in_valid = 1'b1; in_instr = ins; in_pc = pc; wb_valid = 1'b0;
        #1;
        if (pending) check_bundle();
        check_eq("in_ready_accept", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; pending = 0;
        for (int i = 0; i < nstall; i++) begin
            r = $urandom();
            wb_valid = 1'b1; wb_rd = r[4:0]; wb_data = $urandom();
            #1;
            check_eq("stall_wren", rf_wren_a, wb_rd != 5'd0);
            check_eq("stall_addr_a", rf_address_a, wb_rd);
            check_eq("stall_in_a", rf_in_a, wb_data);
            check_eq("stall_out_valid", out_valid, 0);
            check_eq("stall_in_ready", in_ready, 0);
            @(posedge clk);
            if (wb_rd != 5'd0) gold[wb_rd] = wb_data;
            @(negedge clk);
        end
        wb_valid = 1'b0;
        #1;
        check_eq("issue_addr_a", rf_address_a, rs1);
        check_eq("issue_addr_b", rf_address_b, rs2);
        check_eq("issue_wren", rf_wren_a, 0);
        check_eq("issue_out_valid", out_valid, 0);
        exp_rs1 = gold[rs1];
        exp_rs2 = gold[rs2];
        @(posedge clk); @(negedge clk);
        wb_valid = wait_wb; wb_rd = wait_rd; wb_data = wait_data;
        #1;
        check_eq("wait_out_valid", out_valid, 0);
        check_eq("wait_wren", rf_wren_a, wait_wb && (wait_rd != 5'd0));
        @(posedge clk);
        if (wait_wb) apply_wb(wait_rd, wait_data, rs1, rs2);
        @(negedge clk);
        wb_valid = 1'b0;
        exp_ins = ins; exp_pc = pc;
        ref_decode(ins, exp_imm, exp_ill);
        #1;
        check_bundle();
        for (int i = 0; i < nhold; i++) begin
            r = $urandom();
            in_valid = r[0]; in_instr = $urandom();
            wb_valid = hold_wb && r[1];
            wb_rd    = r[7] ? rs1 : (r[8] ? rs2 : r[6:2]);
            wb_data  = $urandom();
            #1;
            check_eq("hold_in_ready", in_ready, 0);
            check_bundle();
            @(posedge clk);
            if (wb_valid) apply_wb(wb_rd, wb_data, rs1, rs2);
            @(negedge clk);
        end
        in_valid = 1'b0; wb_valid = 1'b0;
        pending = 1;
    endtask

    task automatic release_bundle();
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        check_bundle();
        check_eq("release_in_ready", in_ready, 1);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0; pending = 0;
        #1;
        check_eq("idle_out_valid", out_valid, 0);
        check_eq("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] r;
        rst = 1'b1; ru_init = 1'b1; pending = 0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) gold[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; ru_init = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_out_imm", out_imm, 0);
        check_eq("rst_out_illegal", out_illegal, 0);

        // add x7,x5,x6 with no writeback traffic
        wb_idle(5'd5, 32'h11);
        wb_idle(5'd6, 32'h22);
        do_txn(32'h006283B3, 32'h100, 0, 0, 5'd0, 32'd0, 0, 0);
        check_eq("add_rs1", out_rs1_val, 32'h11);
        check_eq("add_rs2", out_rs2_val, 32'h22);
        check_eq("add_rd", out_rd, 32'd7);
        check_eq("add_imm", out_imm, 32'd0);
        release_bundle();

        // addi x1,x0,-1 stalled three cycles by writebacks
        do_txn(32'hFFF00093, 32'h104, 3, 0, 5'd0, 32'd0, 0, 0);
        check_eq("addi_imm", out_imm, 32'hFFFF_FFFF);
        check_eq("addi_rs1", out_rs1_val, 32'd0);
        release_bundle();

        wb_idle(5'd0, 32'hDEAD_BEEF);

        // all-zero word is illegal; held five cycles with a competing request
        do_txn(32'h0000_0000, 32'h108, 0, 0, 5'd0, 32'd0, 5, 0);
        check_eq("zero_illegal", out_illegal, 1);
        check_eq("zero_imm", out_imm, 32'd0);
        release_bundle();

        // add x3,x1,x2 with x1 written while the read is in flight
        wb_idle(5'd1, 32'h1111);
        wb_idle(5'd2, 32'h2222);
        do_txn(32'h002081B3, 32'h10C, 0, 1, 5'd1, 32'hABCD, 0, 0);
`ifdef DECODE_WB_BYPASS_EN
        check_eq("byp_rs1", out_rs1_val, 32'hABCD);
`else
        check_eq("byp_rs1", out_rs1_val, 32'h1111);
`endif
        check_eq("byp_rs2", out_rs2_val, 32'h2222);
        release_bundle();

        // back-to-back acceptance from VALID
        do_txn(rand_instr(), 32'h200, 1, 0, 5'd0, 32'd0, 2, 1);
        do_txn(rand_instr(), 32'h204, 0, 0, 5'd0, 32'd0, 1, 1);
        release_bundle();

        // reset asserted while the read is in WAIT
        in_valid = 1'b1; in_instr = 32'h006283B3; in_pc = 32'h300;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready", in_ready, 1);
        check_eq("arst_out_pc", out_pc, 0);
        check_eq("arst_out_rs1", out_rs1_val, 0);
        check_eq("arst_out_rs2", out_rs2_val, 0);
        check_eq("arst_out_opcode", out_opcode, 0);
        check_eq("arst_out_rd", out_rd, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("arst_idle_out_valid", out_valid, 0);
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            r   = $urandom();
            ins = rand_instr();
            if (!pending && r[0]) wb_idle(r[5:1], $urandom());
            do_txn(ins, $urandom(), int'(r[7:6]) % 3, r[8],
                   r[9] ? ins[19:15] : (r[10] ? ins[24:20] : r[15:11]),
                   $urandom(), int'(r[17:16]), 1);
            if (r[18]) release_bundle();
        end
        if (pending) release_bundle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
